// File: rtl/swipt_pkg.sv
// Shared types and constants for the SWIPT H-bridge sequencing controller.
package swipt_pkg;

  typedef enum logic [2:0] {
    IDLE,
    DIV,
    RESTART,
    RAMP,
    RUN
  } sched_state_t;

  localparam int CLK_HZ     = 100_000_000;
  localparam int FMIN       = 25_000;
  localparam int FMAX       = 1_000_000;
  localparam int DUTY_MAX   = 480;
  localparam int DIV_CYCLES = 28;

endpackage

// File: rtl/swipt_div.sv
// Serial restoring divider, 28-bit numerator by 20-bit divisor, one quotient bit per clock.
module swipt_div
  import swipt_pkg::*;
(
  input  logic        clk,
  input  logic        nrst,
  input  logic        start,
  input  logic        abort,
  input  logic [27:0] num,
  input  logic [19:0] den,
  output logic        done,
  output logic [12:0] quot
);

  logic [20:0] rem;
  logic [27:0] q;
  logic [19:0] d;
  logic [4:0]  cnt;
  logic        run;

  logic [20:0] shifted;
  logic [21:0] trial;

  assign shifted = {rem[19:0], q[27]};
  assign trial   = {1'b0, shifted} - {2'b00, d};
  assign quot    = q[12:0];

  always_ff @(posedge clk) begin
    if (!nrst) begin
      rem  <= '0;
      q    <= '0;
      d    <= '0;
      cnt  <= '0;
      run  <= 1'b0;
      done <= 1'b0;
    end else begin
      done <= 1'b0;
      if (abort) begin
        run <= 1'b0;
      end else if (start) begin
        rem <= '0;
        q   <= num;
        d   <= den;
        cnt <= 5'(DIV_CYCLES - 1);
        run <= 1'b1;
      end else if (run) begin
        // Keep the shifted remainder when the trial subtraction goes negative.
        if (!trial[21]) begin
          rem <= trial[20:0];
          q   <= {q[26:0], 1'b1};
        end else begin
          rem <= shifted;
          q   <= {q[26:0], 1'b0};
        end
        if (cnt == 5'd0) begin
          run  <= 1'b0;
          done <= 1'b1;
        end else begin
          cnt <= cnt - 5'd1;
        end
      end
    end
  end

endmodule

// File: rtl/swipt_sched.sv
// SWIPT H-bridge scheduler: request range check, period division, driver restart and duty soft-ramp.
module swipt_sched
  import swipt_pkg::*;
#(
  parameter int CLK_HZ     = swipt_pkg::CLK_HZ,
  parameter int FMIN       = swipt_pkg::FMIN,
  parameter int FMAX       = swipt_pkg::FMAX,
  parameter int DUTY_MAX   = swipt_pkg::DUTY_MAX,
  parameter int STEP       = 50,
  parameter int RST_CYCLES = 4
) (
  input  logic        clk,
  input  logic        nrst,
  input  logic        enable,
  input  logic        req_valid,
  input  logic [19:0] req_freq,
  input  logic [11:0] req_duty,
  output logic        req_ready,
  output logic        err,
  input  logic        cycle_end,
  output logic        drv_nrst,
  output logic [19:0] drv_freq,
  output logic [11:0] drv_l,
  output logic [12:0] period_cnt,
  output logic        busy
);

  localparam logic signed [12:0] STEP_S = 13'(STEP);
  localparam logic signed [12:0] DMAX_S = 13'(DUTY_MAX);

  sched_state_t state, state_n;
  logic [19:0]  tgt_freq;
  logic [11:0]  tgt_duty;
  logic         loaded;
  logic [7:0]   rst_cnt;

  logic         req_ok, accept, acc_ok, same_freq;
  logic         div_start, div_done;
  logic [19:0]  div_den;
  logic [12:0]  div_quot;

  function automatic logic [11:0] sat_duty(input logic signed [12:0] v);
    if (v < 13'sd0)
      return 12'd0;
    else if (v > DMAX_S)
      return 12'(DUTY_MAX);
    else
      return v[11:0];
  endfunction

  function automatic logic [11:0] first_step(input logic [11:0] tgt);
    return (tgt > 12'(STEP)) ? 12'(STEP) : tgt;
  endfunction

  function automatic logic [11:0] ramp_step(input logic [11:0] cur, input logic [11:0] tgt);
    logic signed [12:0] cur_s, diff, mag;
    cur_s = $signed({1'b0, cur});
    diff  = $signed({1'b0, tgt}) - cur_s;
    mag   = (diff < 13'sd0) ? -diff : diff;
    if (mag > STEP_S)
      mag = STEP_S;
    return sat_duty((diff < 13'sd0) ? (cur_s - mag) : (cur_s + mag));
  endfunction

  assign req_ok    = (req_freq >= 20'(FMIN)) && (req_freq <= 20'(FMAX)) &&
                     (req_duty <= 12'(DUTY_MAX));
  assign accept    = req_valid && req_ready;
  assign acc_ok    = accept && req_ok;
  assign same_freq = (req_freq == drv_freq);

  always_comb begin
    state_n = state;
    if (!enable) begin
      state_n = IDLE;
    end else begin
      case (state)
        IDLE:    if (!acc_ok && loaded) state_n = DIV;
        DIV:     if (div_done) state_n = RESTART;
        RESTART: if (rst_cnt == 8'd0) state_n = RAMP;
        RAMP:    if (drv_l == tgt_duty) state_n = RUN;
        RUN:     state_n = RUN;
        default: state_n = IDLE;
      endcase
      if ((state == RAMP || state == RUN) && acc_ok) begin
        if (!same_freq)
          state_n = DIV;
        else if (drv_l != req_duty)
          state_n = RAMP;
      end
    end
  end

  // Divider is launched on the edge that enters DIV so its 28 iterations fill the DIV window.
  assign div_start = (state_n == DIV) && (state != DIV);
  assign div_den   = (state == IDLE) ? tgt_freq : req_freq;

  swipt_div u_div (
    .clk   (clk),
    .nrst  (nrst),
    .start (div_start),
    .abort (!enable),
    .num   (28'(CLK_HZ)),
    .den   (div_den),
    .done  (div_done),
    .quot  (div_quot)
  );

  always_ff @(posedge clk) begin
    if (!nrst) begin
      state      <= IDLE;
      req_ready  <= 1'b0;
      err        <= 1'b0;
      drv_nrst   <= 1'b0;
      busy       <= 1'b0;
      drv_freq   <= '0;
      drv_l      <= '0;
      period_cnt <= '0;
      tgt_freq   <= '0;
      tgt_duty   <= '0;
      loaded     <= 1'b0;
      rst_cnt    <= '0;
    end else begin
      state     <= state_n;
      req_ready <= (state_n == IDLE) || (state_n == RAMP) || (state_n == RUN);
      busy      <= (state_n == DIV) || (state_n == RESTART) || (state_n == RAMP);
      err       <= accept && !req_ok;

      if (!enable) begin
        drv_nrst <= 1'b0;
        drv_l    <= '0;
        if (acc_ok) begin
          tgt_freq <= req_freq;
          tgt_duty <= req_duty;
          loaded   <= 1'b1;
        end
      end else begin
        case (state)
          IDLE: begin
            if (acc_ok) begin
              tgt_freq <= req_freq;
              tgt_duty <= req_duty;
              loaded   <= 1'b1;
            end
          end
          DIV: begin
            if (div_done) begin
              period_cnt <= div_quot;
              drv_freq   <= tgt_freq;
              drv_l      <= first_step(tgt_duty);
              rst_cnt    <= 8'(RST_CYCLES - 1);
            end
          end
          RESTART: begin
            if (rst_cnt == 8'd0)
              drv_nrst <= 1'b1;
            else
              rst_cnt <= rst_cnt - 8'd1;
          end
          RAMP, RUN: begin
            // A step taken alongside an accepted request still targets the old duty.
            if (state == RAMP && drv_l != tgt_duty && cycle_end)
              drv_l <= ramp_step(drv_l, tgt_duty);
            if (acc_ok) begin
              tgt_duty <= req_duty;
              if (!same_freq) begin
                tgt_freq <= req_freq;
                drv_nrst <= 1'b0;
              end
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_swipt_sched.sv
// Directed self-checking bench for swipt_sched with hand-computed expected values.
module tb_swipt_sched;

  logic        clk = 1'b0;
  logic        nrst, enable, req_valid, cycle_end;
  logic [19:0] req_freq;
  logic [11:0] req_duty;
  logic        req_ready, err, drv_nrst, busy;
  logic [19:0] drv_freq;
  logic [11:0] drv_l;
  logic [12:0] period_cnt;

  int errs   = 0;
  int checks = 0;
  int n_per, n_rise;

  always #5 clk = ~clk;

  swipt_sched dut (
    .clk        (clk),
    .nrst       (nrst),
    .enable     (enable),
    .req_valid  (req_valid),
    .req_freq   (req_freq),
    .req_duty   (req_duty),
    .req_ready  (req_ready),
    .err        (err),
    .cycle_end  (cycle_end),
    .drv_nrst   (drv_nrst),
    .drv_freq   (drv_freq),
    .drv_l      (drv_l),
    .period_cnt (period_cnt),
    .busy       (busy)
  );

  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input int f, input int d);
    req_valid = 1'b1;
    req_freq  = 20'(f);
    req_duty  = 12'(d);
    tick();
    req_valid = 1'b0;
  endtask

  // Called with the DIV-entry edge already taken; counts edges to the period load and to drv_nrst rising.
  task automatic wait_restart(input int pexp, output int np, output int nr);
    nr = 0;
    np = -1;
    while (!drv_nrst && nr < 200) begin
      tick();
      nr++;
      if (np < 0 && int'(period_cnt) == pexp) np = nr;
    end
  endtask

  task automatic step_chk(input string tag, input int exp);
    cycle_end = 1'b1;
    tick();
    cycle_end = 1'b0;
    chk(tag, int'(drv_l), exp);
    chk({tag, "_nrst"}, int'(drv_nrst), 1);
    tick();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    nrst = 1'b0; enable = 1'b0; req_valid = 1'b0; cycle_end = 1'b0;
    req_freq = '0; req_duty = '0;
    tick(); tick();
    chk("rst_ready", int'(req_ready), 0);
    chk("rst_drv_nrst", int'(drv_nrst), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_err", int'(err), 0);
    chk("rst_period", int'(period_cnt), 0);
    chk("rst_drv_l", int'(drv_l), 0);
    chk("rst_drv_freq", int'(drv_freq), 0);

    nrst = 1'b1; enable = 1'b1;
    tick();
    chk("idle_ready", int'(req_ready), 1);

    // First start-up: 100 kHz, duty 300
    send(100_000, 300);
    chk("idle_busy", int'(busy), 0);
    tick();
    chk("div_busy", int'(busy), 1);
    chk("div_ready", int'(req_ready), 0);
    chk("div_drv_nrst", int'(drv_nrst), 0);
    wait_restart(1000, n_per, n_rise);
    chk("t1_period_edge", n_per, 29);
    chk("t1_rise_edge", n_rise, 33);
    chk("t1_period", int'(period_cnt), 1000);
    chk("t1_freq", int'(drv_freq), 100_000);
    chk("t1_l0", int'(drv_l), 50);
    chk("t1_ramp_busy", int'(busy), 1);
    step_chk("t1_l1", 100);
    step_chk("t1_l2", 150);
    step_chk("t1_l3", 200);
    step_chk("t1_l4", 250);
    step_chk("t1_l5", 300);
    chk("t1_run_busy", int'(busy), 0);
    chk("t1_run_ready", int'(req_ready), 1);

    // Range rejections
    send(10_000, 300);
    chk("rej_f_err", int'(err), 1);
    tick();
    chk("rej_f_err_clr", int'(err), 0);
    send(100_000, 600);
    chk("rej_d_err", int'(err), 1);
    tick();
    chk("rej_d_err_clr", int'(err), 0);
    send(1_000_001, 100);
    chk("rej_fmax_err", int'(err), 1);
    tick();
    chk("rej_freq", int'(drv_freq), 100_000);
    chk("rej_l", int'(drv_l), 300);
    chk("rej_busy", int'(busy), 0);

    // Duty-only ramp down
    send(100_000, 200);
    chk("dn_err", int'(err), 0);
    chk("dn_busy", int'(busy), 1);
    step_chk("dn_l1", 250);
    step_chk("dn_l2", 200);
    chk("dn_run_busy", int'(busy), 0);
    chk("dn_freq", int'(drv_freq), 100_000);

    // Frequency change forces a full restart
    send(200_000, 300);
    chk("t4_busy", int'(busy), 1);
    chk("t4_drv_nrst", int'(drv_nrst), 0);
    wait_restart(500, n_per, n_rise);
    chk("t4_period_edge", n_per, 29);
    chk("t4_rise_edge", n_rise, 33);
    chk("t4_period", int'(period_cnt), 500);
    chk("t4_l0", int'(drv_l), 50);
    step_chk("t4_l1", 100);

    // Drop enable mid-ramp, then rerun from stored targets
    enable = 1'b0;
    tick();
    chk("en_drv_nrst", int'(drv_nrst), 0);
    chk("en_l", int'(drv_l), 0);
    chk("en_busy", int'(busy), 0);
    chk("en_ready", int'(req_ready), 1);
    tick();
    enable = 1'b1;
    tick();
    chk("re_busy", int'(busy), 1);
    req_valid = 1'b1; req_freq = 20'd300_000; req_duty = 12'd100;
    for (int i = 0; i < 5; i++) begin
      chk("div_hold_ready", int'(req_ready), 0);
      tick();
    end
    req_valid = 1'b0;
    wait_restart(500, n_per, n_rise);
    chk("re_rise_edge", n_rise + 5, 33);
    chk("re_freq", int'(drv_freq), 200_000);
    chk("re_period", int'(period_cnt), 500);
    chk("re_l0", int'(drv_l), 50);

    // Accept together with cycle_end: step uses the old target (300), then heads to 0
    req_valid = 1'b1; req_freq = 20'd200_000; req_duty = 12'd0;
    cycle_end = 1'b1;
    tick();
    req_valid = 1'b0; cycle_end = 1'b0;
    chk("co_l", int'(drv_l), 100);
    tick();
    step_chk("co_l1", 50);
    step_chk("co_l2", 0);
    chk("co_run_busy", int'(busy), 0);
    chk("co_drv_nrst", int'(drv_nrst), 1);

    // Reset mid-operation
    nrst = 1'b0;
    tick();
    chk("mrst_freq", int'(drv_freq), 0);
    chk("mrst_period", int'(period_cnt), 0);
    chk("mrst_ready", int'(req_ready), 0);
    chk("mrst_drv_nrst", int'(drv_nrst), 0);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule

// File: doc/swipt_sched.md
# swipt_sched

Sequencing controller for the SWIPT H-bridge driver. Accepts frequency and duty requests from the host over a valid/ready handshake and range-checks them. Computes the bridge period with a serial divider, restarts the driver when the frequency changes, and soft-ramps the duty so that a new pulse length is applied only at full-period boundaries reported by the driver.

## Interface
Parameters:
- CLK_HZ, 100_000_000: system clock frequency; the divider numerator.
- FMIN, 25_000: lowest legal frequency in Hz.
- FMAX, 1_000_000: highest legal frequency in Hz.
- DUTY_MAX, 480: highest legal duty, in per-mille.
- STEP, 50: maximum duty change per bridge period, in per-mille.
- RST_CYCLES, 4: number of clocks `drv_nrst` is held low on a restart.

Ports:
- clk, in, 1: clock.
- nrst, in, 1: reset; synchronous, active-low.
- enable, in, 1: run permission; low forces IDLE.
- req_valid, in, 1: request valid.
- req_freq, in, 20: requested frequency in Hz.
- req_duty, in, 12: requested duty in per-mille.
- req_ready, out, 1: request can be accepted this cycle.
- err, out, 1: one-cycle pulse when a request is rejected.
- cycle_end, in, 1: one-cycle pulse from the driver at each full-period boundary.
- drv_nrst, out, 1: driver reset, active-low.
- drv_freq, out, 20: frequency applied to the driver.
- drv_l, out, 12: duty applied to the driver, in per-mille.
- period_cnt, out, 13: CLK_HZ/drv_freq; status output.
- busy, out, 1: high in states DIV, RESTART and RAMP.

## Operation
- States:
  - IDLE: `req_ready`=1.
  - DIV: `req_ready`=0.
  - RESTART: `req_ready`=0.
  - RAMP: `req_ready`=1.
  - RUN: `req_ready`=1.
- Reset values: state IDLE; `req_ready`, `err`, `drv_nrst`, `busy` all 0; `drv_freq`, `drv_l`, `period_cnt` all 0; internal `loaded`=0.
- A request is accepted on a clock edge where `req_valid && req_ready`.
- Range check at acceptance: reject if `req_freq` is below FMIN or above FMAX, or if `req_duty` > DUTY_MAX. A rejected request pulses `err` high for one cycle and changes no state or target.
- Valid request in IDLE: store `tgt_freq` and `tgt_duty`, set `loaded`=1, stay in IDLE.
- IDLE transitions to DIV when `enable && loaded`.
- Valid request in RAMP or RUN:
  - If `req_freq` == `drv_freq`: duty-only update. Set `tgt_duty` and go to RAMP if `drv_l` != `tgt_duty`; otherwise stay.
  - If the frequency differs: store both targets and go to DIV.
- DIV:
  - `drv_nrst`=0.
  - Run the serial restoring division CLK_HZ/`tgt_freq`: 28 iterations, one per clock, truncating quotient.
  - On done: load `period_cnt`, set `drv_freq`=`tgt_freq`, set `drv_l`=min(STEP, `tgt_duty`), go to RESTART.
- RESTART: hold `drv_nrst`=0 for RST_CYCLES clocks, then go to RAMP with `drv_nrst`=1.
- RAMP: on each `cycle_end`, move `drv_l` toward `tgt_duty` by min(STEP, |difference|), up or down. Go to RUN when equal.
- RUN: hold all outputs. `cycle_end` is ignored.
- `enable` low in any state: next clock goes to IDLE with `drv_nrst`=0 and `drv_l`=0. An in-flight division is aborted. Targets and `loaded` are kept, so re-enabling reruns DIV.
- `req_accept` and `cycle_end` in the same cycle during RAMP: this step uses the old `tgt_duty`; the new target applies from the next cycle.
- `drv_l` never exceeds DUTY_MAX. Ramp arithmetic is 13-bit signed; no wrap is permitted.
- `nrst` low mid-operation: all registers return to reset values on that edge; any pending request is discarded.

## Timing
- `err` is registered: high exactly on the cycle after the accepting edge t0.
- Frequency-change path, from accept edge t0:
  - State DIV at t0+1.
  - `period_cnt`, `drv_freq` and `drv_l` update at t0+29 (entry to RESTART).
  - `drv_nrst` low from t0+29 through t0+32, rises at t0+33.
- From IDLE, count t0 from the first edge where `enable && loaded` holds.
- Duty steps take effect on the clock after the corresponding `cycle_end` edge.
- `req_ready` is a registered decode of the state; it drops on the cycle DIV is entered.
- `busy` follows the state with the same one-cycle registration.

## Structure
- Shared package `swipt_pkg` holds:
  - the state enum `sched_state_t` (IDLE, DIV, RESTART, RAMP, RUN);
  - constants CLK_HZ, FMIN, FMAX, DUTY_MAX;
  - DIV_CYCLES = 28.
- Sub-module `swipt_div`: restoring divider, 28-bit by 20-bit, with start/done handshake and an abort input.
  - done is a one-cycle pulse.
  - Quotient is 13 bits; it fits because FMIN ≥ CLK_HZ/8191.
- FSM and ramp logic live in `swipt_sched`.

## Test plan
- Reset, `enable`=1, request 100_000 Hz / duty 300 → `period_cnt`=1000 and `drv_nrst` rises 33 cycles after accept. Then drive `cycle_end` pulses → `drv_l` goes 50, 100, 150, 200, 250, 300, then state RUN.
- Request 10_000 Hz, then separately duty 600 → `err` pulses one cycle for each; `drv_freq` and `drv_l` are unchanged.
- In RUN at duty 300, request the same frequency with duty 200 → `drv_l` goes 250, then 200 on successive `cycle_end` pulses; `drv_nrst` stays 1 throughout.
- In RUN, request 200_000 Hz / duty 300 → full restart: `period_cnt`=500, `drv_nrst` low for 4 cycles, ramp restarts from 50.
- Drop `enable` mid-RAMP → next cycle `drv_nrst`=0, `drv_l`=0, state IDLE. Raise `enable` → rerun with the stored targets; `drv_nrst` rises 33 cycles later.
- Hold `req_valid` during DIV → `req_ready`=0 and the request is not accepted. In RAMP, assert `req_accept` and `cycle_end` together → the step uses the old target.
